// File: rtl/spi_frame_controller.sv
// SPI master that runs an audio ADC read, a round-robin trim-pot read and a DAC write
// on every rising edge of the sample strobe.
module spi_frame_controller #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_clock,
  input  logic [DATA_W-1:0] dac,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              cs_adc,
  output logic              cs_dac,
  output logic [DATA_W-1:0] adc,
  output logic              adc_valid,
  output logic [7:0]        trim1,
  output logic [7:0]        trim2,
  output logic [7:0]        trim3,
  output logic [7:0]        trim4,
  output logic [1:0]        trim_mux,
  output logic              busy,
  output logic              overrun
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [DATA_W-1:0] CMD_AUD   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] CMD_TRIM  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AUD  = 3'd1,
    GAP1 = 3'd2,
    TRIM = 3'd3,
    GAP2 = 3'd4,
    DACW = 3'd5,
    GAP3 = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [DIV_W-1:0]    div_cnt_r, div_cnt_s;
  logic [HALF_W-1:0]   half_cnt_r, half_cnt_s;
  logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;
  logic [DATA_W-1:0]   tx_sr_r, tx_sr_s;
  logic [DATA_W-1:0]   rx_sr_r, rx_sr_s;
  logic [DATA_W-1:0]   dac_lat_r, dac_lat_s;
  logic [DATA_W-1:0]   adc_r, adc_s;
  logic [3:0][7:0]     trim_r, trim_s;
  logic [1:0]          trim_mux_r, trim_mux_s;
  logic                sclk_r, sclk_s;
  logic                mosi_r, mosi_s;
  logic                cs_adc_r, cs_adc_s;
  logic                cs_dac_r, cs_dac_s;
  logic                adc_valid_r, adc_valid_s;
  logic                busy_r, busy_s;
  logic                overrun_r, overrun_s;
  logic                adc_clock_q_r;

  logic                start_s;
  logic                half_end_s;
  logic                frame_end_s;
  logic                gap_end_s;
  logic                load_s;
  logic [DATA_W-1:0]   load_word_s;

  assign start_s     = adc_clock & ~adc_clock_q_r;
  assign half_end_s  = (div_cnt_r == DIV_LAST);
  assign frame_end_s = half_end_s && (half_cnt_r == HALF_LAST);
  assign gap_end_s   = (gap_cnt_r == GAP_LAST);

  // Next-state and next-output computation for the sequencer and SPI shifter
  always_comb begin
    state_s     = state_r;
    div_cnt_s   = div_cnt_r;
    half_cnt_s  = half_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    tx_sr_s     = tx_sr_r;
    rx_sr_s     = rx_sr_r;
    dac_lat_s   = dac_lat_r;
    adc_s       = adc_r;
    trim_s      = trim_r;
    trim_mux_s  = trim_mux_r;
    sclk_s      = sclk_r;
    mosi_s      = mosi_r;
    cs_adc_s    = cs_adc_r;
    cs_dac_s    = cs_dac_r;
    busy_s      = busy_r;
    adc_valid_s = 1'b0;
    overrun_s   = 1'b0;
    load_s      = 1'b0;
    load_word_s = {DATA_W{1'b0}};

    if (start_s && (state_r != IDLE)) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s     = AUD;
          busy_s      = 1'b1;
          dac_lat_s   = dac;
          cs_adc_s    = 1'b0;
          load_s      = 1'b1;
          load_word_s = CMD_AUD;
        end else begin
          busy_s = 1'b0;
        end
      end

      AUD, TRIM, DACW: begin
        if (half_end_s) begin
          div_cnt_s  = {DIV_W{1'b0}};
          half_cnt_s = half_cnt_r + HALF_W'(1'b1);
          sclk_s     = ~sclk_r;
          // Even half-periods end on a rising edge, odd ones on a falling edge
          if (!half_cnt_r[0]) begin
            rx_sr_s = {rx_sr_r[DATA_W-2:0], miso};
          end else begin
            tx_sr_s = {tx_sr_r[DATA_W-2:0], 1'b0};
            mosi_s  = tx_sr_r[DATA_W-2];
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1'b1);
        end

        if (frame_end_s) begin
          cs_adc_s  = 1'b1;
          cs_dac_s  = 1'b1;
          sclk_s    = 1'b0;
          mosi_s    = 1'b0;
          gap_cnt_s = {GAP_W{1'b0}};
          case (state_r)
            AUD: begin
              state_s     = GAP1;
              adc_s       = rx_sr_r;
              adc_valid_s = 1'b1;
            end
            TRIM: begin
              state_s             = GAP2;
              trim_s[trim_mux_r]  = rx_sr_r[DATA_W-1 -: 8];
            end
            default: begin
              state_s = GAP3;
            end
          endcase
        end else begin
          gap_cnt_s = gap_cnt_r;
        end
      end

      GAP1, GAP2, GAP3: begin
        if (gap_end_s) begin
          case (state_r)
            GAP1: begin
              state_s     = TRIM;
              cs_adc_s    = 1'b0;
              load_s      = 1'b1;
              load_word_s = CMD_TRIM;
            end
            GAP2: begin
              state_s     = DACW;
              cs_dac_s    = 1'b0;
              load_s      = 1'b1;
              load_word_s = dac_lat_r;
            end
            default: begin
              state_s    = IDLE;
              busy_s     = 1'b0;
              trim_mux_s = trim_mux_r + 2'd1;
            end
          endcase
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_W'(1'b1);
        end
      end

      default: begin
        state_s  = IDLE;
        cs_adc_s = 1'b1;
        cs_dac_s = 1'b1;
        sclk_s   = 1'b0;
        mosi_s   = 1'b0;
        busy_s   = 1'b0;
      end
    endcase

    // Frame entry: first bit must already be on mosi when chip select falls
    if (load_s) begin
      tx_sr_s    = load_word_s;
      mosi_s     = load_word_s[DATA_W-1];
      rx_sr_s    = {DATA_W{1'b0}};
      div_cnt_s  = {DIV_W{1'b0}};
      half_cnt_s = {HALF_W{1'b0}};
      sclk_s     = 1'b0;
    end else begin
      tx_sr_s = tx_sr_s;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      div_cnt_r     <= {DIV_W{1'b0}};
      half_cnt_r    <= {HALF_W{1'b0}};
      gap_cnt_r     <= {GAP_W{1'b0}};
      tx_sr_r       <= {DATA_W{1'b0}};
      rx_sr_r       <= {DATA_W{1'b0}};
      dac_lat_r     <= {DATA_W{1'b0}};
      adc_r         <= {DATA_W{1'b0}};
      trim_r        <= {32{1'b0}};
      trim_mux_r    <= 2'd0;
      sclk_r        <= 1'b0;
      mosi_r        <= 1'b0;
      cs_adc_r      <= 1'b1;
      cs_dac_r      <= 1'b1;
      adc_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
      adc_clock_q_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      div_cnt_r     <= div_cnt_s;
      half_cnt_r    <= half_cnt_s;
      gap_cnt_r     <= gap_cnt_s;
      tx_sr_r       <= tx_sr_s;
      rx_sr_r       <= rx_sr_s;
      dac_lat_r     <= dac_lat_s;
      adc_r         <= adc_s;
      trim_r        <= trim_s;
      trim_mux_r    <= trim_mux_s;
      sclk_r        <= sclk_s;
      mosi_r        <= mosi_s;
      cs_adc_r      <= cs_adc_s;
      cs_dac_r      <= cs_dac_s;
      adc_valid_r   <= adc_valid_s;
      busy_r        <= busy_s;
      overrun_r     <= overrun_s;
      adc_clock_q_r <= adc_clock;
    end
  end

  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign cs_adc    = cs_adc_r;
  assign cs_dac    = cs_dac_r;
  assign adc       = adc_r;
  assign adc_valid = adc_valid_r;
  assign trim1     = trim_r[0];
  assign trim2     = trim_r[1];
  assign trim3     = trim_r[2];
  assign trim4     = trim_r[3];
  assign trim_mux  = trim_mux_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule
